pwm_capture: RTL
================

// Module: pwm_capture
// PURPOSE
//  - Receive side of the on-chip PWM link: measures an incoming PWM waveform and recovers its duty code.
//  - Reports high time, period and an 8-bit duty code matching the pwm_generator duty encoding (256-clk frame).
//  - Used for loopback self-test of pwm_generator and for external PWM sensing on a uio input pin.
// PARAMETERS
//  CNT_W    16    width of high-time/period counters; must be >= 9
//  TIMEOUT  1024  clk cycles with no edge before a stuck level is declared; must be < 2**CNT_W
//  FILT_LEN 3     cycles the input must be stable before a level change is accepted (PWM_CAP_FILTER_EN only)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  ena        in   1      capture enable; low = idle and hold results
//  pwm_in     in   1      asynchronous PWM input
//  duty       out  8      recovered duty code, min(high_time,255)
//  high_time  out  CNT_W  high cycles of the last complete period
//  period     out  CNT_W  clk cycles between the last two rising edges
//  valid      out  1      one-cycle pulse when duty/high_time/period update
//  stuck_hi   out  1      input held high >= TIMEOUT cycles
//  stuck_lo   out  1      input held low >= TIMEOUT cycles, or never toggled
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. Reset: all outputs 0, state IDLE, counters 0.
//  - pwm_in passes through a 2-FF synchronizer giving pwm_s; edges are detected against pwm_s delayed by 1 cycle.
//  - Latency: a rising edge sampled at clk k appears as an edge-detect pulse at k+3 (+FILT_LEN when the filter is built in).
//  - FSM states:
//    IDLE: counters cleared; wait for a rising edge -> HIGH. No capture on this first edge.
//    HIGH: hcnt++ and pcnt++ every cycle; falling edge -> LOW.
//    LOW: pcnt++ every cycle; rising edge -> capture, clear counters, -> HIGH.
//  - Capture: high_time<=hcnt, period<=pcnt, duty<=(hcnt>255)?8'hFF:hcnt[7:0], valid=1 for exactly one cycle.
//    Counts include the edge cycle, so an ideal 256-cycle frame with code D gives high_time=D and period=256.
//  - Counters saturate at 2**CNT_W-1 and never wrap.
//  - Timeout: a separate idle counter is cleared on any edge.
//    It reaches TIMEOUT in HIGH -> stuck_hi=1, duty=8'hFF, high_time=period=0, one valid pulse, -> IDLE.
//    It reaches TIMEOUT in LOW/IDLE -> stuck_lo=1, duty=0, high_time=period=0, one valid pulse, -> IDLE.
//    In IDLE it fires once only, with no repeated valid pulses.
//  - stuck_hi/stuck_lo clear on the next detected edge of either polarity.
//    They are mutually exclusive and are never both 1.
//  - ena=0: FSM forced to IDLE and counters cleared. Outputs and stuck flags hold, valid=0. The synchronizer keeps running.
//  - ena rising: restart from IDLE. The first complete period after re-enable is the first capture.
//  - Rising and falling edges never coincide in one cycle, because pwm_s is a single bit.
// CONFIGURATION
//  PWM_CAP_FILTER_EN defined: a FILT_LEN-deep stability filter is inserted after the synchronizer.
//    pwm_s changes only after FILT_LEN consecutive equal samples. Pulses shorter than FILT_LEN cycles are ignored.
//    Latency grows by FILT_LEN cycles.
//  PWM_CAP_FILTER_EN undefined: no filter, and FILT_LEN is unused. A single-cycle pulse is measured as high_time=1.
// TESTING
//  1 Reset mid-stream with rst_n=0 and no clk edge -> all outputs 0 immediately; the first capture after release needs two rising edges.
//  2 Loopback from pwm_generator at duty=8'h40 -> from the 2nd rising edge on: valid every 256 cycles, duty=8'h40, high_time=64, period=256.
//  3 Input constant 0 from reset -> after TIMEOUT=1024 cycles: stuck_lo=1, one valid pulse, duty=0; no further valid pulses.
//  4 Input held high for 2000 cycles -> stuck_hi=1, duty=8'hFF, one valid pulse; the next falling edge clears stuck_hi.
//  5 Drop ena for 10 cycles mid-HIGH during a duty 8'h80 stream -> no valid pulse for that period; outputs hold 8'h80; capture resumes after two rising edges.
//  6 With PWM_CAP_FILTER_EN: inject a 2-cycle low glitch into a duty 8'hC0 stream -> duty stays 8'hC0. Without the macro -> a short capture occurs (high_time<192).

Source files
------------

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Receive side of the on-chip PWM link. Measures an incoming PWM waveform and
//   recovers high time, period and an 8-bit duty code that uses the same
//   encoding as pwm_generator (256-clk frame, code D -> D high cycles).
//
//   Optional build macro: PWM_CAP_FILTER_EN
//     When defined, a FILT_LEN-deep stability filter follows the synchronizer.
//     The filter rejects input pulses shorter than FILT_LEN cycles.
//
// Parameters
//   CNT_W     width of the high-time/period/idle counters (>= 9)
//   TIMEOUT   edge-free cycles before a stuck level is declared (< 2**CNT_W)
//   FILT_LEN  filter depth; only used when PWM_CAP_FILTER_EN is defined
//
// Ports
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous active-low reset
//   ena        in   1      capture enable; low = idle, results held
//   pwm_in     in   1      asynchronous PWM input
//   duty       out  8      recovered duty code, min(high_time,255)
//   high_time  out  CNT_W  high cycles of the last complete period
//   period     out  CNT_W  cycles between the last two rising edges
//   valid      out  1      one-cycle pulse when the results update
//   stuck_hi   out  1      input held high for TIMEOUT cycles
//   stuck_lo   out  1      input held low for TIMEOUT cycles / never toggled
//   dbg_state  out  2      current FSM state (0 IDLE, 1 HIGH, 2 LOW)
//
// Handshake: valid is a pure strobe with no ready. duty, high_time, period,
// stuck_hi and stuck_lo are stable in the cycle valid is high and hold their
// values until the next valid pulse (or until an edge clears the stuck flags).
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1024,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pwm_in,
  output logic [7:0]       duty,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             stuck_hi,
  output logic             stuck_lo,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMO_FULL = CNT_W'(TIMEOUT);

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_pwm_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [FW-1:0] r_fcnt;
  logic          r_filt;

  // The filtered level follows the synchronized input only after FILT_LEN
  // consecutive samples that disagree with it; any agreeing sample restarts
  // the count, so shorter pulses never reach the edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt <= '0;
      r_filt <= 1'b0;
    end else if (r_sync2 == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FW'(FILT_LEN - 1)) begin
      r_filt <= r_sync2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign w_pwm_s = r_filt;
`else
  logic w_unused_filt;
  assign w_unused_filt = (FILT_LEN != 0);
  assign w_pwm_s       = r_sync2;
`endif

  // ---------------------------------------------------------------------------
  // Edge detection (registered, so rise and fall are single-cycle pulses)
  // ---------------------------------------------------------------------------
  logic r_pwm_d;
  logic r_rise;
  logic r_fall;
  logic w_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_d <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_pwm_d <= w_pwm_s;
      r_rise  <= w_pwm_s & ~r_pwm_d;
      r_fall  <= ~w_pwm_s & r_pwm_d;
    end
  end

  assign w_edge = r_rise | r_fall;

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_icnt;
  logic [CNT_W-1:0] w_hcnt_nx;
  logic [CNT_W-1:0] w_pcnt_nx;
  logic             r_tmo_done;
  logic             w_tmo;
  logic             w_cap;
  logic             w_tmo_hi;
  logic             w_tmo_lo;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Timeout fires on the TIMEOUT-th edge-free cycle. r_tmo_done keeps it from
  // re-firing while the level stays stuck; the next edge re-arms it.
  assign w_tmo = ena && !r_tmo_done && !w_edge && (r_icnt >= TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_hcnt  <= w_hcnt_nx;
      r_pcnt  <= w_pcnt_nx;
    end
  end

  // The rising-edge cycle is counted as the first cycle of the new period,
  // hence the reload to 1 instead of 0. The falling-edge cycle already belongs
  // to the low phase, so it advances pcnt only.
  always_comb begin
    w_state_nx = r_state;
    w_hcnt_nx  = r_hcnt;
    w_pcnt_nx  = r_pcnt;
    w_cap      = 1'b0;
    w_tmo_hi   = 1'b0;
    w_tmo_lo   = 1'b0;
    if (!ena) begin
      w_state_nx = ST_IDLE;
      w_hcnt_nx  = '0;
      w_pcnt_nx  = '0;
    end else if (w_tmo) begin
      w_tmo_hi   = (r_state == ST_HIGH);
      w_tmo_lo   = (r_state != ST_HIGH);
      w_state_nx = ST_IDLE;
      w_hcnt_nx  = '0;
      w_pcnt_nx  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_hcnt_nx = '0;
          w_pcnt_nx = '0;
          if (r_rise) begin
            w_state_nx = ST_HIGH;
            w_hcnt_nx  = CNT_W'(1);
            w_pcnt_nx  = CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (r_fall) begin
            w_state_nx = ST_LOW;
            w_pcnt_nx  = sat_inc(r_pcnt);
          end else begin
            w_hcnt_nx = sat_inc(r_hcnt);
            w_pcnt_nx = sat_inc(r_pcnt);
          end
        end
        ST_LOW: begin
          if (r_rise) begin
            w_cap      = 1'b1;
            w_state_nx = ST_HIGH;
            w_hcnt_nx  = CNT_W'(1);
            w_pcnt_nx  = CNT_W'(1);
          end else begin
            w_pcnt_nx = sat_inc(r_pcnt);
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_hcnt_nx  = '0;
          w_pcnt_nx  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Idle (edge-free) counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icnt     <= '0;
      r_tmo_done <= 1'b0;
    end else if (!ena || w_edge) begin
      r_icnt     <= '0;
      r_tmo_done <= 1'b0;
    end else begin
      if (r_icnt != TMO_FULL) begin
        r_icnt <= r_icnt + 1'b1;
      end
      if (w_tmo) begin
        r_tmo_done <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty      <= 8'h00;
      high_time <= '0;
      period    <= '0;
      valid     <= 1'b0;
      stuck_hi  <= 1'b0;
      stuck_lo  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (ena && w_edge) begin
        stuck_hi <= 1'b0;
        stuck_lo <= 1'b0;
      end
      if (w_cap) begin
        high_time <= r_hcnt;
        period    <= r_pcnt;
        duty      <= (r_hcnt > CNT_W'(255)) ? 8'hFF : r_hcnt[7:0];
        valid     <= 1'b1;
      end else if (w_tmo_hi) begin
        high_time <= '0;
        period    <= '0;
        duty      <= 8'hFF;
        stuck_hi  <= 1'b1;
        stuck_lo  <= 1'b0;
        valid     <= 1'b1;
      end else if (w_tmo_lo) begin
        high_time <= '0;
        period    <= '0;
        duty      <= 8'h00;
        stuck_hi  <= 1'b0;
        stuck_lo  <= 1'b1;
        valid     <= 1'b1;
      end
    end
  end

  assign dbg_state = r_state;

endmodule
